alu_seq_muldiv: RTL

Parametrised, handshaked successor to the single-cycle RISC-V ALU. It keeps the base integer ops and VCNZ flags, with result and flags registered. It adds iterative unsigned multiply and divide/remainder (RV32M subset), computed one bit per cycle. It sits in the execute stage of the multi-cycle core; the control FSM stalls on the valid/ready handshake.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_iter_core.sv | 89 ++++++++
 rtl/alu_seq_muldiv.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU with iterative multiply/divide.
// Optional build macro: ALU_SIGNED_DIV_EN adds signed DIV/REM to the iterative set.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLTU  = 4'b0110,
    OP_MUL   = 4'b1000,
    OP_MULHU = 4'b1001,
    OP_DIVU  = 4'b1010,
    OP_REMU  = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_REM   = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ops that go through the one-bit-per-cycle core instead of the fast path.
  function automatic logic is_iterative(alu_op_e op);
    case (op)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: return 1'b1;
`ifdef ALU_SIGNED_DIV_EN
      OP_DIV, OP_REM: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Iterative ops that use the restoring divider rather than the shift-add multiplier.
  function automatic logic is_divide(alu_op_e op);
    case (op)
      OP_DIVU, OP_REMU, OP_DIV, OP_REM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Ops whose answer sits in the upper half of the accumulator (high product / remainder).
  function automatic logic takes_high_half(alu_op_e op);
    case (op)
      OP_MULHU, OP_REMU, OP_REM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
// The 2*WIDTH accumulator holds {high product, multiplier} or {remainder, quotient}.
// done pulses on the cycle of the final step; res_lo/res_hi then show the finished value.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               active_q, active_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  // One multiply or divide step computed from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    div_ok    = (rem_sh >= {1'b0, opnd_q});
    rem_diff  = rem_sh[WIDTH-1:0] - opnd_q;
    div_next  = {(div_ok ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};
    step_next = div_q ? div_next : mul_next;
  end

  assign done   = active_q && (cnt_q == CNT_W'(1));
  assign res_lo = step_next[WIDTH-1:0];
  assign res_hi = step_next[2*WIDTH-1:WIDTH];

  // Load operands on start, otherwise step and count down while active.
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    active_d = active_q;
    if (start) begin
      div_d    = is_divide(op);
      acc_d    = {{WIDTH{1'b0}}, (is_divide(op) ? a : b)};
      opnd_d   = is_divide(op) ? b : a;
      cnt_d    = CNT_W'(WIDTH);
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d = step_next;
      cnt_d = cnt_q - CNT_W'(1);
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  // State registers; reset abandons any step sequence in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Handshaked execute-stage ALU: single-cycle base ops, iterative MUL/MULHU/DIVU/REMU.
// Result and VCNZ flags are registered and held until out_ready.
// Optional build macro: ALU_SIGNED_DIV_EN enables signed DIV/REM via an abs/sign-fix wrapper.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Result,
  output logic             oVerflow,
  output logic             Carry,
  output logic             Negative,
  output logic             Zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MSB = WIDTH - 1;

  alu_op_e          op_in;
  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] fast_res;
  logic             fast_v, fast_c;
  logic             core_start, core_done;
  logic [WIDTH-1:0] core_a, core_b, core_lo, core_hi;
  logic [WIDTH-1:0] iter_res;

`ifdef ALU_SIGNED_DIV_EN
  logic sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic signed_op;
`endif

  assign op_in = alu_op_e'(ALUControl);

  // Single-cycle ops; unsupported codes yield zero with no V/C.
  always_comb begin
    add_full = {1'b0, A} + {1'b0, B};
    sub_full = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    fast_res = '0;
    fast_v   = 1'b0;
    fast_c   = 1'b0;
    case (op_in)
      OP_ADD: begin
        fast_res = add_full[MSB:0];
        fast_c   = add_full[WIDTH];
        fast_v   = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
      end
      OP_SUB: begin
        fast_res = sub_full[MSB:0];
        fast_c   = sub_full[WIDTH];
        fast_v   = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);
      end
      OP_AND:  fast_res = A & B;
      OP_OR:   fast_res = A | B;
      OP_XOR:  fast_res = A ^ B;
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: fast_res = '0;
    endcase
  end

  // Operands handed to the unsigned core; signed divides feed magnitudes.
  always_comb begin
`ifdef ALU_SIGNED_DIV_EN
    signed_op = (op_in == OP_DIV) || (op_in == OP_REM);
    sa_d      = signed_op && A[MSB];
    sb_d      = signed_op && B[MSB];
    bz_d      = (B == '0);
    core_a    = sa_d ? -A : A;
    core_b    = sb_d ? -B : B;
`else
    core_a    = A;
    core_b    = B;
`endif
  end

  alu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .op     (op_in),
    .a      (core_a),
    .b      (core_b),
    .done   (core_done),
    .res_lo (core_lo),
    .res_hi (core_hi)
  );

  // Pick the accumulator half for the op in flight and restore the sign if needed.
  always_comb begin
    iter_res = takes_high_half(op_q) ? core_hi : core_lo;
`ifdef ALU_SIGNED_DIV_EN
    if (op_q == OP_DIV) begin
      if (bz_q)             iter_res = '1;
      else if (sa_q ^ sb_q) iter_res = -iter_res;
    end else if (op_q == OP_REM) begin
      if (sa_q) iter_res = -iter_res;
    end
`endif
  end

  // Control FSM: IDLE accepts, BUSY waits for the core, DONE holds until out_ready.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    result_d    = result_q;
    v_d         = v_q;
    c_d         = c_q;
    n_d         = n_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    core_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d       = op_in;
          in_ready_d = 1'b0;
          if (is_iterative(op_in)) begin
            core_start = 1'b1;
            state_d    = BUSY;
          end else begin
            result_d    = fast_res;
            v_d         = fast_v;
            c_d         = fast_c;
            n_d         = fast_res[MSB];
            z_d         = (fast_res == '0);
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      BUSY: begin
        if (core_done) begin
          result_d    = iter_res;
          v_d         = 1'b0;
          c_d         = 1'b0;
          n_d         = iter_res[MSB];
          z_d         = (iter_res == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // FSM state, registered result/flags and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      result_q    <= '0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ALU_SIGNED_DIV_EN
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      bz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      result_q    <= result_d;
      v_q         <= v_d;
      c_q         <= c_d;
      n_q         <= n_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ALU_SIGNED_DIV_EN
      if (core_start) begin
        sa_q <= sa_d;
        sb_q <= sb_d;
        bz_q <= bz_d;
      end
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign oVerflow  = v_q;
  assign Carry     = c_q;
  assign Negative  = n_q;
  assign Zero      = z_q;

endmodule
